deser400_tp_scan_ctrl: RTL
==========================

Name: deser400_tp_scan_ctrl

Overview:
Controller for the deser400 test-point multiplexer pair: drives its 7-bit sela/selb selects and measures the selected tpa/tpb signals. In static mode, host configuration is applied directly to the selects. In scan mode, the block owns sela, steps it from a first to a last index, and reports rising-edge counts of tpa and tpb over a programmable dwell window per index. It sits between the host register bank and the test-point mux, and accounts for the mux's 2-register pipeline latency.

Parameters:
DWELL_W, 16, width of dwell counter and cfg_dwell
CNT_W, 16, width of edge counters count_a/count_b
SETTLE, 3, blanking cycles after a sela change (2 mux register stages + 1 edge-detect register)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cfg_we  in  1  write strobe for cfg_sela/cfg_selb
cfg_sela  in  7  static select A
cfg_selb  in  7  static select B (also reference channel during scan)
cfg_first  in  7  first scan index
cfg_last  in  7  last scan index
cfg_dwell  in  DWELL_W  measure window length in clk cycles
start  in  1  pulse: begin scan
stop  in  1  pulse: abort scan
tpa  in  1  mux output A
tpb  in  1  mux output B
sela  out  7  select A to mux
selb  out  7  select B to mux
busy  out  1  scan in progress
result_valid  out  1  one-cycle pulse per scanned index
result_sel  out  7  sela value the result belongs to
count_a  out  CNT_W  tpa rising edges in window
count_b  out  CNT_W  tpb rising edges in window
done  out  1  one-cycle pulse on normal scan completion

Behaviour:
- Reset: clk is the clock; reset is asynchronous, active-high. All outputs and internal state go to 0; FSM goes to IDLE.
- Edge detect: tpa_d/tpb_d are registered every cycle. A rising edge is tpx & ~tpx_d.
- States: IDLE, SETTLE, MEASURE, REPORT.
- IDLE, static operation:
  - cfg_we: sela <= cfg_sela and selb <= cfg_selb on the next edge.
  - busy=0.
- IDLE, start and not stop:
  - Shadow-register cfg_first, cfg_last and cfg_dwell (dwell 0 treated as 1).
  - sela <= cfg_first; clear counters; -> SETTLE; busy=1 from the next cycle.
- SETTLE:
  - Count SETTLE cycles, with no edge counting.
  - Then -> MEASURE.
- MEASURE:
  - For exactly dwell cycles, add edge_a/edge_b to count_a/count_b.
  - Counters saturate at all-ones.
  - Then -> REPORT.
- REPORT (1 cycle):
  - result_valid=1; result_sel=sela; count_a/count_b hold final values and stay stable until the next clear.
  - If sela==last_shadow: done=1 in this same cycle, -> IDLE, busy drops next cycle.
  - Otherwise: sela <= sela+1 modulo 128, counters cleared, -> SETTLE.
  - If first > last, the scan wraps 127 -> 0 and continues until last.
- Scan-mode select ownership:
  - A cfg_we during a scan updates selb only; the cfg_sela write is discarded.
  - Changes to cfg_first/last/dwell mid-scan have no effect.
- stop in any non-IDLE state:
  - -> IDLE next cycle, busy=0, no result_valid, no done.
  - sela keeps its current value; counters are held.
- Other boundary rules:
  - start while busy is ignored.
  - start and stop in the same cycle in IDLE: stop wins, no scan.
  - first==last: a single-index scan (one result, then done).
- Latency per index: SETTLE + dwell + 1 cycles. A full scan of N indices takes N*(SETTLE+dwell+1) cycles from the cycle after start.
- Reset mid-scan: immediate return to reset values; no result or done pulse.

Test Plan:
- Static mode: cfg_we with cfg_sela=7'h25, cfg_selb=7'h41 -> sela=0x25, selb=0x41 one cycle later; busy stays 0.
- Scan 3..5, dwell=10, tpa toggling every cycle (5 rising edges per 10 cycles), tpb=0 -> three result_valid pulses, 14 cycles apart, with result_sel=3,4,5, count_a=5, count_b=0; done coincides with the third pulse.
- Wrap scan first=126, last=1, dwell=4 -> result_sel sequence 126,127,0,1, then done.
- Saturation: CNT_W overridden to 4, dwell=40, tpa toggling -> count_a=15.
- stop asserted during MEASURE of the second index -> busy low next cycle; only one result_valid; no done.
- start+stop same cycle -> no busy. cfg_we mid-scan with cfg_sela=9, cfg_selb=2 -> selb=2, sela scan sequence undisturbed. reset mid-SETTLE -> all outputs 0.

Source files
------------

// File: rtl/deser400_tp_scan_ctrl_if.sv
// rtl/deser400_tp_scan_ctrl_if.sv - host/mux side signal bundle for the test-point scan controller
interface deser400_tp_scan_ctrl_if #(
    parameter int DWELL_W = 16,
    parameter int CNT_W   = 16
);
    logic               cfg_we;
    logic [6:0]         cfg_sela;
    logic [6:0]         cfg_selb;
    logic [6:0]         cfg_first;
    logic [6:0]         cfg_last;
    logic [DWELL_W-1:0] cfg_dwell;
    logic               start;
    logic               stop;
    logic               tpa;
    logic               tpb;
    logic [6:0]         sela;
    logic [6:0]         selb;
    logic               busy;
    logic               result_valid;
    logic [6:0]         result_sel;
    logic [CNT_W-1:0]   count_a;
    logic [CNT_W-1:0]   count_b;
    logic               done;

    modport master (
        output cfg_we, cfg_sela, cfg_selb, cfg_first, cfg_last, cfg_dwell, start, stop, tpa, tpb,
        input  sela, selb, busy, result_valid, result_sel, count_a, count_b, done
    );

    modport slave (
        input  cfg_we, cfg_sela, cfg_selb, cfg_first, cfg_last, cfg_dwell, start, stop, tpa, tpb,
        output sela, selb, busy, result_valid, result_sel, count_a, count_b, done
    );
endinterface

// File: rtl/deser400_tp_scan_ctrl.sv
// rtl/deser400_tp_scan_ctrl.sv - test-point mux select driver with per-index edge-count scan
module deser400_tp_scan_ctrl #(
    parameter int DWELL_W = 16,
    parameter int CNT_W   = 16,
    parameter int SETTLE  = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    deser400_tp_scan_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_MEASURE, ST_REPORT} state_t;

    localparam logic [DWELL_W-1:0] SETTLE_LAST = DWELL_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;

    state_t             state_q, state_d;
    logic [6:0]         sela_q, sela_d;
    logic [6:0]         selb_q, selb_d;
    logic [6:0]         last_q, last_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]   cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]   cnt_b_q, cnt_b_d;
    logic               tpa_d_q, tpb_d_q;
    logic               edge_a, edge_b;
    logic               result_valid;
    logic               done;

    assign edge_a = bus.tpa & ~tpa_d_q;
    assign edge_b = bus.tpb & ~tpb_d_q;

    always_comb begin
        state_d      = state_q;
        sela_d       = sela_q;
        selb_d       = selb_q;
        last_d       = last_q;
        dwell_d      = dwell_q;
        timer_d      = timer_q;
        cnt_a_d      = cnt_a_q;
        cnt_b_d      = cnt_b_q;
        result_valid = 1'b0;
        done         = 1'b0;

        // selb is always host-owned; sela only while idle
        if (bus.cfg_we) selb_d = bus.cfg_selb;

        if (state_q != ST_IDLE && bus.stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.cfg_we) sela_d = bus.cfg_sela;
                    if (bus.start && !bus.stop) begin
                        sela_d  = bus.cfg_first;
                        last_d  = bus.cfg_last;
                        dwell_d = (bus.cfg_dwell == '0) ? DWELL_W'(1) : bus.cfg_dwell;
                        timer_d = '0;
                        cnt_a_d = '0;
                        cnt_b_d = '0;
                        state_d = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (timer_q == SETTLE_LAST) begin
                        timer_d = '0;
                        state_d = ST_MEASURE;
                    end else begin
                        timer_d = timer_q + DWELL_W'(1);
                    end
                end
                ST_MEASURE: begin
                    if (edge_a && cnt_a_q != CNT_MAX) cnt_a_d = cnt_a_q + CNT_W'(1);
                    if (edge_b && cnt_b_q != CNT_MAX) cnt_b_d = cnt_b_q + CNT_W'(1);
                    if (timer_q == dwell_q - DWELL_W'(1)) begin
                        timer_d = '0;
                        state_d = ST_REPORT;
                    end else begin
                        timer_d = timer_q + DWELL_W'(1);
                    end
                end
                ST_REPORT: begin
                    result_valid = 1'b1;
                    if (sela_q == last_q) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        sela_d  = sela_q + 7'd1;
                        cnt_a_d = '0;
                        cnt_b_d = '0;
                        timer_d = '0;
                        state_d = ST_SETTLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sela_q  <= '0;
            selb_q  <= '0;
            last_q  <= '0;
            dwell_q <= '0;
            timer_q <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            tpa_d_q <= 1'b0;
            tpb_d_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sela_q  <= sela_d;
            selb_q  <= selb_d;
            last_q  <= last_d;
            dwell_q <= dwell_d;
            timer_q <= timer_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            tpa_d_q <= bus.tpa;
            tpb_d_q <= bus.tpb;
        end
    end

    assign bus.sela         = sela_q;
    assign bus.selb         = selb_q;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.result_valid = result_valid;
    assign bus.result_sel   = (state_q == ST_REPORT) ? sela_q : 7'd0;
    assign bus.count_a      = cnt_a_q;
    assign bus.count_b      = cnt_b_q;
    assign bus.done         = done;
endmodule
